// File: rtl/rvsteel_reset_sequencer_if.sv
// rvsteel_reset_sequencer_if: button/halt inputs and SoC reset/halt/status outputs of the reset sequencer
interface rvsteel_reset_sequencer_if;
  logic button_in;
  logic halt_request;
  logic soc_reset;
  logic soc_halt;
  logic running;
  logic [7:0] button_reset_count;
  modport master (
    output button_in, halt_request,
    input soc_reset, soc_halt, running, button_reset_count
  );
  modport slave (
    input button_in, halt_request,
    output soc_reset, soc_halt, running, button_reset_count
  );
endinterface

// File: rtl/rvsteel_reset_sequencer.sv
// rvsteel_reset_sequencer: synchronizes and debounces the reset button, holds soc_reset after release
// and arbitrates halt requests against button resets (a debounced press always wins).
module rvsteel_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter bit BUTTON_ACTIVE_HIGH = 1
) (
  input logic clock,
  input logic reset,
  rvsteel_reset_sequencer_if.slave bus
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = RESET_HOLD_CYCLES > 1 ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic PRESSED_LEVEL = BUTTON_ACTIVE_HIGH;
  typedef enum logic [1:0] {ASSERT, HOLD, RUN, HALT} state_t;
  state_t state;
  state_t state_next;
  logic [1:0] sync;
  logic debounced;
  logic pressed;
  logic debounce_done;
  logic hold_done;
  logic [DW-1:0] debounce_count;
  logic [HW-1:0] hold_count;
  assign pressed = sync[1] == PRESSED_LEVEL;
  assign debounce_done = debounce_count == DW'(DEBOUNCE_CYCLES - 1);
  assign hold_done = hold_count == HW'(RESET_HOLD_CYCLES - 1);
  // Synchronizer resets to the pressed level so the SoC stays in reset until a clean release is seen
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync <= {2{PRESSED_LEVEL}};
      debounced <= 1'b1;
      debounce_count <= '0;
    end else begin
      sync <= {sync[0], bus.button_in};
      debounced <= pressed != debounced && debounce_done ? pressed : debounced;
      debounce_count <= pressed == debounced || debounce_done ? '0 : debounce_count + 1'b1;
    end
  always_comb begin
    state_next = state;
    state_next = debounced ? ASSERT :
                 state == ASSERT ? HOLD :
                 state == HOLD ? (hold_done ? RUN : HOLD) :
                 bus.halt_request ? HALT : RUN;
  end
  // Outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ASSERT;
      hold_count <= '0;
      bus.soc_reset <= 1'b1;
      bus.soc_halt <= 1'b0;
      bus.running <= 1'b0;
      bus.button_reset_count <= '0;
    end else begin
      state <= state_next;
      hold_count <= state == HOLD && state_next == HOLD ? hold_count + 1'b1 : '0;
      bus.soc_reset <= state_next == ASSERT || state_next == HOLD;
      bus.soc_halt <= state_next == HALT;
      bus.running <= state_next == RUN;
      if (debounced && (state == RUN || state == HALT) && bus.button_reset_count != 8'hFF)
        bus.button_reset_count <= bus.button_reset_count + 1'b1;
    end
endmodule

// File: tb/tb_rvsteel_reset_sequencer.sv
// tb_rvsteel_reset_sequencer: directed stimulus, per-cycle comparison against a behavioural model,
// plus hand-computed latency and counter expectations.
module tb_rvsteel_reset_sequencer;
  localparam int D = 4;
  localparam int H = 3;
  localparam int H2 = 12;
  localparam bit AH = 1;
  localparam int P_ASSERT = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN = 2;
  localparam int P_HALT = 3;
  logic clock;
  logic reset;
  logic reset2;
  int n_chk = 0;
  int n_fail = 0;
  rvsteel_reset_sequencer_if bus();
  rvsteel_reset_sequencer_if bus2();
  rvsteel_reset_sequencer #(.DEBOUNCE_CYCLES(D), .RESET_HOLD_CYCLES(H), .BUTTON_ACTIVE_HIGH(AH)) u_dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  // Longer hold so a debounced press can land while still in HOLD
  rvsteel_reset_sequencer #(.DEBOUNCE_CYCLES(D), .RESET_HOLD_CYCLES(H2), .BUTTON_ACTIVE_HIGH(AH)) u_dut2 (
    .clock(clock),
    .reset(reset2),
    .bus(bus2.slave)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: raw samples through a 2-deep queue, debounce as "last D samples all differ", phase timing from edge count
  logic [1:0] m_q;
  logic [D-1:0] m_win;
  logic m_deb;
  logic m_pr;
  int m_phase;
  int m_t;
  int m_hold_t;
  int m_cnt;
  assign m_pr = m_q[1] == AH;
  always @(posedge clock or posedge reset)
    if (reset) begin
      m_q <= {2{AH}};
      m_win <= '1;
      m_deb <= 1'b1;
      m_phase <= P_ASSERT;
      m_t <= 0;
      m_hold_t <= 0;
      m_cnt <= 0;
    end else begin
      m_t <= m_t + 1;
      m_q <= {m_q[0], bus.button_in};
      m_win <= {m_win[D-2:0], m_pr};
      if ({m_win[D-2:0], m_pr} == {D{~m_deb}}) m_deb <= ~m_deb;
      case (m_phase)
        P_ASSERT: if (!m_deb) begin m_phase <= P_HOLD; m_hold_t <= m_t; end
        P_HOLD: if (m_deb) m_phase <= P_ASSERT; else if (m_t - m_hold_t >= H) m_phase <= P_RUN;
        default:
          if (m_deb) begin
            m_phase <= P_ASSERT;
            m_cnt <= m_cnt == 255 ? 255 : m_cnt + 1;
          end else m_phase <= bus.halt_request ? P_HALT : P_RUN;
      endcase
    end
  always @(negedge clock) begin
    chk("model_soc_reset", bus.soc_reset, m_phase == P_ASSERT || m_phase == P_HOLD);
    chk("model_soc_halt", bus.soc_halt, m_phase == P_HALT);
    chk("model_running", bus.running, m_phase == P_RUN);
    chk("model_count", bus.button_reset_count, m_cnt);
  end
  task automatic wait_run(input string name);
    int n = 0;
    while (!bus.running && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk(name, bus.running, 1);
  endtask
  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    bus.button_in = 1'b0;
    bus.halt_request = 1'b0;
    bus2.button_in = 1'b0;
    bus2.halt_request = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_soc_reset", bus.soc_reset, 1);
    chk("rst_soc_halt", bus.soc_halt, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_count", bus.button_reset_count, 0);
    // Power-on release with button released
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock); #1;
      chk("poweron_soc_reset", bus.soc_reset, e < 10);
      chk("poweron_running", bus.running, e >= 10);
    end
    // Glitch shorter than the debounce window
    @(negedge clock); bus.button_in = 1'b1;
    repeat (3) @(negedge clock);
    bus.button_in = 1'b0;
    repeat (10) @(negedge clock);
    chk("glitch_soc_reset", bus.soc_reset, 0);
    chk("glitch_count", bus.button_reset_count, 0);
    chk("glitch_running", bus.running, 1);
    // Press held 8 cycles from RUN
    @(negedge clock); bus.button_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock); #1;
      chk("press_soc_reset", bus.soc_reset, e == 7);
    end
    chk("press_count", bus.button_reset_count, 1);
    @(negedge clock);
    @(negedge clock); bus.button_in = 1'b0;
    for (int e = 9; e <= 18; e++) begin
      @(posedge clock); #1;
      chk("release_soc_reset", bus.soc_reset, e < 18);
    end
    chk("release_running", bus.running, 1);
    // Halt set/clear, then press while halted
    @(negedge clock); bus.halt_request = 1'b1;
    @(posedge clock); #1;
    chk("halt_set", bus.soc_halt, 1);
    chk("halt_running", bus.running, 0);
    @(negedge clock); bus.halt_request = 1'b0;
    @(posedge clock); #1;
    chk("halt_clear", bus.soc_halt, 0);
    chk("halt_clear_running", bus.running, 1);
    @(negedge clock); bus.halt_request = 1'b1;
    @(negedge clock); bus.button_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock); #1;
      chk("halt_press_soc_halt", bus.soc_halt, e < 7);
      chk("halt_press_soc_reset", bus.soc_reset, e == 7);
    end
    chk("halt_press_count", bus.button_reset_count, 2);
    @(negedge clock);
    @(negedge clock); bus.button_in = 1'b0;
    for (int e = 9; e <= 19; e++) begin
      @(posedge clock); #1;
      chk("halt_ignored_in_reset", bus.soc_halt, e == 19);
    end
    @(negedge clock); bus.halt_request = 1'b0;
    repeat (2) @(negedge clock);
    // Debounced press during HOLD on the long-hold instance
    reset2 = 1'b0;
    for (int e = 1; e <= 7; e++) @(posedge clock);
    @(negedge clock); bus2.button_in = 1'b1;
    for (int e = 8; e <= 13; e++) @(posedge clock);
    @(negedge clock); bus2.button_in = 1'b0;
    for (int e = 14; e <= 33; e++) begin
      @(posedge clock); #1;
      chk("hold_bounce_soc_reset", bus2.soc_reset, e < 32);
      chk("hold_bounce_running", bus2.running, e >= 32);
    end
    chk("hold_bounce_count", bus2.button_reset_count, 0);
    // Async reset mid-HOLD
    @(negedge clock); bus.button_in = 1'b1;
    repeat (8) @(negedge clock);
    bus.button_in = 1'b0;
    for (int e = 9; e <= 16; e++) @(posedge clock);
    #1;
    chk("pre_async_hold_count", bus.button_reset_count, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_hold_soc_reset", bus.soc_reset, 1);
    chk("async_hold_running", bus.running, 0);
    chk("async_hold_count", bus.button_reset_count, 0);
    @(negedge clock); reset = 1'b0;
    wait_run("async_hold_recover");
    // Async reset mid-HALT
    @(negedge clock); bus.halt_request = 1'b1;
    @(posedge clock); #1;
    chk("pre_async_halt", bus.soc_halt, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_halt_soc_halt", bus.soc_halt, 0);
    chk("async_halt_soc_reset", bus.soc_reset, 1);
    chk("async_halt_running", bus.running, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.halt_request = 1'b0;
    wait_run("async_halt_recover");
    // Saturation of the press counter
    for (int i = 0; i < 257; i++) begin
      @(negedge clock); bus.button_in = 1'b1;
      repeat (8) @(negedge clock);
      bus.button_in = 1'b0;
      wait_run("sat_wait_run");
      if (i == 254) chk("count_at_255", bus.button_reset_count, 255);
    end
    chk("count_saturated", bus.button_reset_count, 255);
    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
